// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures decoded instruction state for the EX stage,
// with hold (downstream stall), bubble insertion and a saturating bubble counter.
module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              hold_i,
  input  logic              bubble_i,
  input  logic              ID_RegWrite_i,
  input  logic              ID_MemtoReg_i,
  input  logic              ID_MemRead_i,
  input  logic              ID_MemWrite_i,
  input  logic              ID_ALUSrc_i,
  input  logic [1:0]        ID_ALUOp_i,
  input  logic [DATA_W-1:0] ID_RS1data_i,
  input  logic [DATA_W-1:0] ID_RS2data_i,
  input  logic [DATA_W-1:0] ID_Imm_i,
  input  logic [9:0]        ID_funct_i,
  input  logic [4:0]        ID_Rs1_i,
  input  logic [4:0]        ID_Rs2_i,
  input  logic [4:0]        ID_Rd_i,
  output logic              EX_RegWrite_o,
  output logic              EX_MemtoReg_o,
  output logic              EX_MemRead_o,
  output logic              EX_MemWrite_o,
  output logic              EX_ALUSrc_o,
  output logic [1:0]        EX_ALUOp_o,
  output logic [DATA_W-1:0] EX_RS1data_o,
  output logic [DATA_W-1:0] EX_RS2data_o,
  output logic [DATA_W-1:0] EX_Imm_o,
  output logic [9:0]        EX_funct_o,
  output logic [4:0]        EX_Rs1_o,
  output logic [4:0]        EX_Rs2_o,
  output logic [4:0]        EX_Rd_o,
  output logic              EX_valid_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  logic update;
  logic take_id;
  logic count_bubble;

  // Registers change unless a running core is stalled; when they change they
  // either take the ID values or a bubble (all zero, so no forwarding match).
  assign update       = !start_i || !hold_i;
  assign take_id      = start_i && !hold_i && !bubble_i;
  assign count_bubble = start_i && !hold_i && bubble_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      EX_RegWrite_o <= 1'b0;
      EX_MemtoReg_o <= 1'b0;
      EX_MemRead_o  <= 1'b0;
      EX_MemWrite_o <= 1'b0;
      EX_ALUSrc_o   <= 1'b0;
      EX_ALUOp_o    <= '0;
      EX_RS1data_o  <= '0;
      EX_RS2data_o  <= '0;
      EX_Imm_o      <= '0;
      EX_funct_o    <= '0;
      EX_Rs1_o      <= '0;
      EX_Rs2_o      <= '0;
      EX_Rd_o       <= '0;
      EX_valid_o    <= 1'b0;
    end else if (update) begin
      EX_RegWrite_o <= take_id ? ID_RegWrite_i : 1'b0;
      EX_MemtoReg_o <= take_id ? ID_MemtoReg_i : 1'b0;
      EX_MemRead_o  <= take_id ? ID_MemRead_i  : 1'b0;
      EX_MemWrite_o <= take_id ? ID_MemWrite_i : 1'b0;
      EX_ALUSrc_o   <= take_id ? ID_ALUSrc_i   : 1'b0;
      EX_ALUOp_o    <= take_id ? ID_ALUOp_i    : '0;
      EX_RS1data_o  <= take_id ? ID_RS1data_i  : '0;
      EX_RS2data_o  <= take_id ? ID_RS2data_i  : '0;
      EX_Imm_o      <= take_id ? ID_Imm_i      : '0;
      EX_funct_o    <= take_id ? ID_funct_i    : '0;
      EX_Rs1_o      <= take_id ? ID_Rs1_i      : '0;
      EX_Rs2_o      <= take_id ? ID_Rs2_i      : '0;
      EX_Rd_o       <= take_id ? ID_Rd_i       : '0;
      EX_valid_o    <= take_id;
    end
  end

  // Only stall-driven bubbles are counted; idle bubbles while start_i is low are not.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bubble_cnt_o <= '0;
    end else if (count_bubble && (bubble_cnt_o != {CNT_W{1'b1}})) begin
      bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed self-checking bench for id_ex_pipe_reg; a second instance with a
// 2-bit counter shares all inputs to exercise counter saturation.
module tb_id_ex_pipe_reg;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i, hold_i, bubble_i;
  logic        id_rw, id_mtr, id_mr, id_mw, id_as;
  logic [1:0]  id_aluop;
  logic [31:0] id_rs1d, id_rs2d, id_imm;
  logic [9:0]  id_funct;
  logic [4:0]  id_rs1, id_rs2, id_rd;

  logic        a_rw, a_mtr, a_mr, a_mw, a_as, a_valid;
  logic [1:0]  a_aluop;
  logic [31:0] a_rs1d, a_rs2d, a_imm;
  logic [9:0]  a_funct;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic [15:0] a_cnt;

  logic        b_rw, b_mtr, b_mr, b_mw, b_as, b_valid;
  logic [1:0]  b_aluop;
  logic [31:0] b_rs1d, b_rs2d, b_imm;
  logic [9:0]  b_funct;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [1:0]  b_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  id_ex_pipe_reg #(.DATA_W(32), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .hold_i(hold_i), .bubble_i(bubble_i),
    .ID_RegWrite_i(id_rw), .ID_MemtoReg_i(id_mtr), .ID_MemRead_i(id_mr),
    .ID_MemWrite_i(id_mw), .ID_ALUSrc_i(id_as), .ID_ALUOp_i(id_aluop),
    .ID_RS1data_i(id_rs1d), .ID_RS2data_i(id_rs2d), .ID_Imm_i(id_imm),
    .ID_funct_i(id_funct), .ID_Rs1_i(id_rs1), .ID_Rs2_i(id_rs2), .ID_Rd_i(id_rd),
    .EX_RegWrite_o(a_rw), .EX_MemtoReg_o(a_mtr), .EX_MemRead_o(a_mr),
    .EX_MemWrite_o(a_mw), .EX_ALUSrc_o(a_as), .EX_ALUOp_o(a_aluop),
    .EX_RS1data_o(a_rs1d), .EX_RS2data_o(a_rs2d), .EX_Imm_o(a_imm),
    .EX_funct_o(a_funct), .EX_Rs1_o(a_rs1), .EX_Rs2_o(a_rs2), .EX_Rd_o(a_rd),
    .EX_valid_o(a_valid), .bubble_cnt_o(a_cnt)
  );

  id_ex_pipe_reg #(.DATA_W(32), .CNT_W(2)) dut_small (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .hold_i(hold_i), .bubble_i(bubble_i),
    .ID_RegWrite_i(id_rw), .ID_MemtoReg_i(id_mtr), .ID_MemRead_i(id_mr),
    .ID_MemWrite_i(id_mw), .ID_ALUSrc_i(id_as), .ID_ALUOp_i(id_aluop),
    .ID_RS1data_i(id_rs1d), .ID_RS2data_i(id_rs2d), .ID_Imm_i(id_imm),
    .ID_funct_i(id_funct), .ID_Rs1_i(id_rs1), .ID_Rs2_i(id_rs2), .ID_Rd_i(id_rd),
    .EX_RegWrite_o(b_rw), .EX_MemtoReg_o(b_mtr), .EX_MemRead_o(b_mr),
    .EX_MemWrite_o(b_mw), .EX_ALUSrc_o(b_as), .EX_ALUOp_o(b_aluop),
    .EX_RS1data_o(b_rs1d), .EX_RS2data_o(b_rs2d), .EX_Imm_o(b_imm),
    .EX_funct_o(b_funct), .EX_Rs1_o(b_rs1), .EX_Rs2_o(b_rs2), .EX_Rd_o(b_rd),
    .EX_valid_o(b_valid), .bubble_cnt_o(b_cnt)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_id(input logic rw, input logic mtr, input logic mr, input logic mw,
                          input logic as_, input logic [1:0] aluop, input logic [31:0] rs1d,
                          input logic [31:0] rs2d, input logic [31:0] imm, input logic [9:0] funct,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    id_rw = rw; id_mtr = mtr; id_mr = mr; id_mw = mw; id_as = as_; id_aluop = aluop;
    id_rs1d = rs1d; id_rs2d = rs2d; id_imm = imm; id_funct = funct;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; start_i = 1'b0; hold_i = 1'b0; bubble_i = 1'b0;
    drive_id(1, 1, 1, 1, 1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10'h3FF, 5'd31, 5'd31, 5'd31);
    step(); step();
    checks++;
    if ({a_rw, a_mtr, a_mr, a_mw, a_as, a_aluop, a_valid} !== 8'h00) begin
      errors++; $display("[TB] FAIL reset_ctrl: got %h expected 00", {a_rw, a_mtr, a_mr, a_mw, a_as, a_aluop, a_valid});
    end
    checks++;
    if ({a_rs1d, a_rs2d, a_imm} !== 96'h0) begin
      errors++; $display("[TB] FAIL reset_data: got %h expected 0", {a_rs1d, a_rs2d, a_imm});
    end
    checks++;
    if ({a_funct, a_rs1, a_rs2, a_rd} !== 25'h0) begin
      errors++; $display("[TB] FAIL reset_idx: got %h expected 0", {a_funct, a_rs1, a_rs2, a_rd});
    end
    checks++;
    if (a_cnt !== 16'd0) begin
      errors++; $display("[TB] FAIL reset_cnt: got %0d expected 0", a_cnt);
    end
    #3 rst_i = 1'b1;
  endtask

  task automatic test_load();
    start_i = 1'b1; hold_i = 1'b0; bubble_i = 1'b0;
    drive_id(1, 0, 1, 0, 1, 2'b10, 32'h1234_5678, 32'hCAFE_F00D, 32'hFFFF_FFF0, 10'h2A5, 5'd3, 5'd4, 5'd5);
    step();
    checks++;
    if (a_rd !== 5'd5 || a_rw !== 1'b1 || a_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL load_rd_rw_valid: got rd=%0d rw=%b v=%b expected rd=5 rw=1 v=1", a_rd, a_rw, a_valid);
    end
    checks++;
    if (a_rs1d !== 32'h1234_5678 || a_rs2d !== 32'hCAFE_F00D || a_imm !== 32'hFFFF_FFF0) begin
      errors++; $display("[TB] FAIL load_data: got %h %h %h expected 12345678 cafef00d fffffff0", a_rs1d, a_rs2d, a_imm);
    end
    checks++;
    if ({a_mtr, a_mr, a_mw, a_as, a_aluop} !== 6'b010110 || a_funct !== 10'h2A5 || a_rs1 !== 5'd3 || a_rs2 !== 5'd4) begin
      errors++; $display("[TB] FAIL load_misc: got ctrl=%b funct=%h rs1=%0d rs2=%0d expected ctrl=010110 funct=2a5 rs1=3 rs2=4",
                         {a_mtr, a_mr, a_mw, a_as, a_aluop}, a_funct, a_rs1, a_rs2);
    end
  endtask

  task automatic test_hold();
    hold_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_id(0, 1, 0, 1, 0, 2'b01, 32'h1111_0000 + i, 32'h0, 32'h7, 10'h001, 5'd9, 5'd10, 5'd11 + 5'(i));
      step();
      checks++;
      if (a_rd !== 5'd5 || a_rs1d !== 32'h1234_5678 || a_valid !== 1'b1 || a_rw !== 1'b1 || a_mw !== 1'b0) begin
        errors++; $display("[TB] FAIL hold_%0d: got rd=%0d rs1d=%h v=%b rw=%b mw=%b expected rd=5 rs1d=12345678 v=1 rw=1 mw=0",
                           i, a_rd, a_rs1d, a_valid, a_rw, a_mw);
      end
      checks++;
      if (a_cnt !== 16'd0) begin
        errors++; $display("[TB] FAIL hold_cnt_%0d: got %0d expected 0", i, a_cnt);
      end
    end
    hold_i = 1'b0;
  endtask

  task automatic test_bubble();
    bubble_i = 1'b1;
    drive_id(1, 1, 1, 1, 1, 2'b11, 32'hDEAD_BEEF, 32'h5, 32'h6, 10'h3FF, 5'd1, 5'd2, 5'd7);
    step();
    checks++;
    if ({a_rw, a_mtr, a_mr, a_mw, a_as, a_aluop, a_valid} !== 8'h00 || a_rd !== 5'd0 || a_rs1 !== 5'd0 || a_rs2 !== 5'd0) begin
      errors++; $display("[TB] FAIL bubble_ctrl: got ctrl=%h rd=%0d rs1=%0d rs2=%0d expected all 0",
                         {a_rw, a_mtr, a_mr, a_mw, a_as, a_aluop, a_valid}, a_rd, a_rs1, a_rs2);
    end
    checks++;
    if (a_rs1d !== 32'h0 || a_imm !== 32'h0 || a_funct !== 10'h0) begin
      errors++; $display("[TB] FAIL bubble_data: got %h %h %h expected 0", a_rs1d, a_imm, a_funct);
    end
    checks++;
    if (a_cnt !== 16'd1) begin
      errors++; $display("[TB] FAIL bubble_cnt: got %0d expected 1", a_cnt);
    end
    bubble_i = 1'b0;
  endtask

  task automatic test_hold_bubble();
    drive_id(1, 0, 0, 0, 0, 2'b00, 32'hA5A5_A5A5, 32'h0, 32'h0, 10'h000, 5'd6, 5'd8, 5'd12);
    step();
    hold_i = 1'b1; bubble_i = 1'b1;
    drive_id(0, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 10'h000, 5'd0, 5'd0, 5'd20);
    step();
    checks++;
    if (a_valid !== 1'b1 || a_rd !== 5'd12 || a_rs1d !== 32'hA5A5_A5A5 || a_cnt !== 16'd1) begin
      errors++; $display("[TB] FAIL hold_over_bubble: got v=%b rd=%0d rs1d=%h cnt=%0d expected v=1 rd=12 rs1d=a5a5a5a5 cnt=1",
                         a_valid, a_rd, a_rs1d, a_cnt);
    end
    hold_i = 1'b0;
    step();
    checks++;
    if (a_valid !== 1'b0 || a_rd !== 5'd0 || a_rw !== 1'b0 || a_cnt !== 16'd2) begin
      errors++; $display("[TB] FAIL bubble_after_hold: got v=%b rd=%0d rw=%b cnt=%0d expected v=0 rd=0 rw=0 cnt=2",
                         a_valid, a_rd, a_rw, a_cnt);
    end
    bubble_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [4:0] rds [3];
    logic [31:0] vals [3];
    rds  = '{5'd17, 5'd18, 5'd19};
    vals = '{32'h0000_0001, 32'h8000_0000, 32'h0F0F_0F0F};
    for (int i = 0; i < 3; i++) begin
      drive_id(1, 0, 0, 0, 1, 2'b10, vals[i], ~vals[i], vals[i] ^ 32'h1, 10'h100 + 10'(i), 5'd1, 5'd2, rds[i]);
      step();
      checks++;
      if (a_rd !== rds[i] || a_rs1d !== vals[i] || a_rs2d !== ~vals[i] || a_valid !== 1'b1 || a_funct !== 10'h100 + 10'(i)) begin
        errors++; $display("[TB] FAIL b2b_%0d: got rd=%0d rs1d=%h rs2d=%h v=%b funct=%h expected rd=%0d rs1d=%h rs2d=%h v=1",
                           i, a_rd, a_rs1d, a_rs2d, a_valid, a_funct, rds[i], vals[i], ~vals[i]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_small [5];
    exp_small = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    #2 rst_i = 1'b0;
    #2 rst_i = 1'b1;
    start_i = 1'b1; hold_i = 1'b0; bubble_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (b_cnt !== exp_small[i] || a_cnt !== 16'(i + 1)) begin
        errors++; $display("[TB] FAIL sat_cnt_%0d: got small=%0d wide=%0d expected small=%0d wide=%0d",
                           i, b_cnt, a_cnt, exp_small[i], i + 1);
      end
    end
    bubble_i = 1'b0;
  endtask

  task automatic test_async_reset();
    drive_id(1, 1, 0, 0, 1, 2'b01, 32'h7777_7777, 32'h1, 32'h2, 10'h055, 5'd21, 5'd22, 5'd23);
    step();
    checks++;
    if (a_valid !== 1'b1 || a_rd !== 5'd23 || a_cnt !== 16'd5) begin
      errors++; $display("[TB] FAIL pre_async: got v=%b rd=%0d cnt=%0d expected v=1 rd=23 cnt=5", a_valid, a_rd, a_cnt);
    end
    #2 rst_i = 1'b0;
    #1;
    checks++;
    if (a_valid !== 1'b0 || a_rd !== 5'd0 || a_rw !== 1'b0 || a_rs1d !== 32'h0 || a_cnt !== 16'd0 || b_cnt !== 2'd0) begin
      errors++; $display("[TB] FAIL async_reset: got v=%b rd=%0d rw=%b rs1d=%h cnt=%0d/%0d expected all 0",
                         a_valid, a_rd, a_rw, a_rs1d, a_cnt, b_cnt);
    end
    start_i = 1'b0;
    #2 rst_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bubble_i = (i == 1);
      step();
      checks++;
      if (a_valid !== 1'b0 || a_rd !== 5'd0 || a_rw !== 1'b0 || a_cnt !== 16'd0) begin
        errors++; $display("[TB] FAIL idle_%0d: got v=%b rd=%0d rw=%b cnt=%0d expected v=0 rd=0 rw=0 cnt=0",
                           i, a_valid, a_rd, a_rw, a_cnt);
      end
    end
    start_i = 1'b1; bubble_i = 1'b0;
    step();
    checks++;
    if (a_valid !== 1'b1 || a_rd !== 5'd23 || a_rs1d !== 32'h7777_7777) begin
      errors++; $display("[TB] FAIL resume_load: got v=%b rd=%0d rs1d=%h expected v=1 rd=23 rs1d=77777777", a_valid, a_rd, a_rs1d);
    end
  endtask

  initial begin
    $display("[TB] starting id_ex_pipe_reg bench");
    test_reset();
    test_load();
    test_hold();
    test_bubble();
    test_hold_bubble();
    test_back_to_back();
    test_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
